// File: rtl/if_fetcher.sv
// if_fetcher: IF-stage sequencer that owns the PC and fetches through the ICache.
// A miss goes to the memory controller, then the word is pushed and refilled.
// Ports:
//   query_pc / hit / inst_from_icache : ICache lookup of the current PC
//   ena/addr/inst_to_icache           : one-cycle ICache fill strobe
//   ena/addr_to_memctrl, ok/inst_from : miss fetch request (level until ok)
//   full_from_iq, inst_valid/inst/pc  : instruction queue push
//   jump_flag / jump_target           : redirect from commit (highest priority)
module if_fetcher #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] query_pc,
  input  logic              hit_from_icache,
  input  logic [INST_W-1:0] inst_from_icache,
  output logic              ena_to_icache,
  output logic [ADDR_W-1:0] addr_to_icache,
  output logic [INST_W-1:0] inst_to_icache,
  output logic              ena_to_memctrl,
  output logic [ADDR_W-1:0] addr_to_memctrl,
  input  logic              ok_from_memctrl,
  input  logic [INST_W-1:0] inst_from_memctrl,
  input  logic              full_from_iq,
  output logic              inst_valid_to_iq,
  output logic [INST_W-1:0] inst_to_iq,
  output logic [ADDR_W-1:0] pc_to_iq,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_target
);

  typedef enum logic [1:0] {
    RUN,
    MISS,
    DROP
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] pc, pc_n, pc_inc;
  logic [ADDR_W-1:0] miss_addr, miss_n;
  logic              ic_ena_n;
  logic [ADDR_W-1:0] ic_addr_n;
  logic [INST_W-1:0] ic_inst_n;
  logic              mc_ena_n;
  logic [ADDR_W-1:0] mc_addr_n;
  logic              iq_v_n;
  logic [INST_W-1:0] iq_inst_n;
  logic [ADDR_W-1:0] iq_pc_n;

  assign query_pc = pc;
  assign pc_inc   = pc + ADDR_W'(4);

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    miss_n    = miss_addr;
    ic_ena_n  = 1'b0;
    ic_addr_n = addr_to_icache;
    ic_inst_n = inst_to_icache;
    mc_ena_n  = ena_to_memctrl;
    mc_addr_n = addr_to_memctrl;
    iq_v_n    = 1'b0;
    iq_inst_n = inst_to_iq;
    iq_pc_n   = pc_to_iq;
    unique case (state)
      RUN: begin
        if (jump_flag) begin
          pc_n = jump_target;
        end else if (full_from_iq) begin
          pc_n = pc;
        end else if (hit_from_icache) begin
          iq_v_n    = 1'b1;
          iq_inst_n = inst_from_icache;
          iq_pc_n   = pc;
          pc_n      = pc_inc;
        end else begin
          mc_ena_n  = 1'b1;
          mc_addr_n = pc;
          miss_n    = pc;
          state_n   = MISS;
        end
      end
      MISS: begin
        if (ok_from_memctrl) begin
          ic_ena_n  = 1'b1;
          ic_addr_n = miss_addr;
          ic_inst_n = inst_from_memctrl;
          mc_ena_n  = 1'b0;
          state_n   = RUN;
          if (jump_flag) begin
            pc_n = jump_target;
          end else begin
            iq_v_n    = 1'b1;
            iq_inst_n = inst_from_memctrl;
            iq_pc_n   = miss_addr;
            pc_n      = pc_inc;
          end
        end else if (jump_flag) begin
          // request cannot be withdrawn; wait it out in DROP
          pc_n    = jump_target;
          state_n = DROP;
        end
      end
      DROP: begin
        if (jump_flag) pc_n = jump_target;
        if (ok_from_memctrl) begin
          ic_ena_n  = 1'b1;
          ic_addr_n = miss_addr;
          ic_inst_n = inst_from_memctrl;
          mc_ena_n  = 1'b0;
          state_n   = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      pc               <= RESET_PC;
      miss_addr        <= '0;
      ena_to_icache    <= 1'b0;
      addr_to_icache   <= '0;
      inst_to_icache   <= '0;
      ena_to_memctrl   <= 1'b0;
      addr_to_memctrl  <= '0;
      inst_valid_to_iq <= 1'b0;
      inst_to_iq       <= '0;
      pc_to_iq         <= '0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      miss_addr        <= miss_n;
      ena_to_icache    <= ic_ena_n;
      addr_to_icache   <= ic_addr_n;
      inst_to_icache   <= ic_inst_n;
      ena_to_memctrl   <= mc_ena_n;
      addr_to_memctrl  <= mc_addr_n;
      inst_valid_to_iq <= iq_v_n;
      inst_to_iq       <= iq_inst_n;
      pc_to_iq         <= iq_pc_n;
    end
  end

endmodule
